aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
- Sequencer and round-key store for the AES-128 key-expansion datapath (aes_key_gen).
- Latches the cipher key on a start handshake, then drives en/gen_key/next_rnd/r_con_ctrl to produce round keys 1..10 one per cycle.
- Captures each round key into an 11-entry store, with round key 0 being the cipher key itself.
- Cipher and decipher round stages read any round key by index once the schedule is valid.

Parameters:
- NRND, 10, number of expanded rounds (AES-128); the store holds NRND+1 entries.
- IDXW, 4, width of the round-key read index.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- nrst  input  1  asynchronous active-low reset.
- start_i  input  1  request expansion of key_i; sampled only in IDLE.
- key_i  input  128  cipher key; sampled on the edge that accepts start_i.
- busy_o  output  1  high while expansion is in progress (EXPAND or FINAL).
- done_o  output  1  one-cycle pulse when all 11 round keys are stored.
- keys_valid_o  output  1  store holds a complete schedule for the latched key.
- kg_en_o  output  1  to aes_key_gen en.
- kg_gen_key_o  output  1  to aes_key_gen gen_key; selects r_con_ctrl.
- kg_next_rnd_o  output  1  to aes_key_gen next_rnd.
- kg_rcon_o  output  8  to aes_key_gen r_con_ctrl.
- kg_key_o  output  128  latched cipher key, to aes_key_gen key_i.
- kg_rnd_key_i  input  128  aes_key_gen key_o (registered round key).
- rd_idx_i  input  IDXW  round-key read index, 0..10.
- rd_key_o  output  128  combinational read of store[rd_idx_i].

Behaviour:
- Reset values: state=IDLE, rnd_cnt=0, busy_o=0, done_o=0, keys_valid_o=0, kg_en_o=0, kg_gen_key_o=0, kg_next_rnd_o=0, kg_rcon_o=8'h00, kg_key_o=0. Store array is not reset.
- States: IDLE, EXPAND, FINAL.
- IDLE, start_i=1 at edge E0:
  - kg_key_o <= key_i; store[0] <= key_i.
  - keys_valid_o <= 0; rnd_cnt <= 1; state goes to EXPAND.
- EXPAND, cycle with rnd_cnt=k (k=1..10):
  - kg_en_o=1, kg_gen_key_o=1, kg_next_rnd_o=(k>1).
  - kg_rcon_o = RCON[k] = 01,02,04,08,10,20,40,80,1B,36.
  - For k>=2, store[k-1] <= kg_rnd_key_i at the end of the cycle (one-cycle aes_key_gen pipeline lag).
  - k=10: state goes to FINAL; otherwise rnd_cnt increments.
- FINAL (one cycle):
  - kg_en_o=0 (aes_key_gen holds); store[10] <= kg_rnd_key_i.
  - state goes to IDLE; done_o <= 1; keys_valid_o <= 1.
- Latency: done_o is high in the 12th cycle after E0 (10 EXPAND + 1 FINAL + registered pulse).
- Outside EXPAND, all kg_* control outputs are 0 and kg_rcon_o=0.
- busy_o is 1 in EXPAND and FINAL only.
- start_i while busy: ignored; no queueing.
- start_i in the done_o cycle: accepted (state is IDLE); done_o still pulses exactly once.
- Read port:
  - rd_key_o = store[rd_idx_i] when keys_valid_o=1 and rd_idx_i<=10.
  - Otherwise rd_key_o=0, covering rd_idx_i 11..15 and any invalid schedule.
- Mid-expansion nrst: returns immediately to reset values; keys_valid_o=0, so stale store contents are never visible.
- kg_key_o changes only on an accepted start (required stable for aes_key_gen next_rnd=0).

Optional Feature:
- Macro AES_KEY_REUSE_EN.
- Defined: on an accepted start_i with keys_valid_o=1 and key_i==kg_key_o, expansion is skipped.
  - State stays IDLE; keys_valid_o stays 1; busy_o stays 0.
  - done_o pulses in the next cycle.
  - kg_en_o stays 0, so the aes_key_gen pipeline is untouched.
- Not defined: every accepted start_i performs a full 12-cycle expansion.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse -> after done_o:
  - rd_idx 0 returns 2b7e1516...4f3c.
  - rd_idx 1 returns a0fafe1788542cb123a339392a6c7605.
  - rd_idx 10 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done_o arrives exactly 12 cycles after the start edge.
- Same run, cycle-by-cycle -> kg_rcon_o sequence 01..36, kg_next_rnd_o=0 only in the first EXPAND cycle, kg_en_o low in FINAL.
- start_i held high throughout an expansion -> one expansion only; a second expansion begins the edge done_o is high; done_o pulses once per expansion.
- nrst asserted at rnd_cnt=5 -> all outputs reset asynchronously, keys_valid_o=0, rd_key_o=0 for all indices; a fresh start then completes normally.
- rd_idx_i=11 and 15 with valid schedule -> rd_key_o=0; rd_idx_i=3 before the first expansion -> 0.
- AES_KEY_REUSE_EN defined:
  - Same key restarted after done -> done_o next cycle, busy_o never high.
  - Different key -> full 12-cycle expansion.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer and 11-entry round-key store that drives aes_key_gen.
// Optional build macro AES_KEY_REUSE_EN: restarting with the already-expanded key skips re-expansion.
module aes_key_sched_ctrl #(
  parameter int NRND = 10,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            start_i,
  input  logic [127:0]    key_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            keys_valid_o,
  output logic            kg_en_o,
  output logic            kg_gen_key_o,
  output logic            kg_next_rnd_o,
  output logic [7:0]      kg_rcon_o,
  output logic [127:0]    kg_key_o,
  input  logic [127:0]    kg_rnd_key_i,
  input  logic [IDXW-1:0] rd_idx_i,
  output logic [127:0]    rd_key_o,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    FINAL  = 2'd2
  } state_t;

  localparam logic [3:0]      CNT_LAST = 4'(NRND);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NRND);
  localparam logic [7:0] RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  // Handshake: start_i is a request honoured only on an edge where the FSM is IDLE; there is
  // no ready/ack, so a request while busy is dropped. done_o is a one-cycle completion strobe.
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [127:0]  key_q;
  logic          valid_q, done_q;
  logic [127:0]  store [NRND+1];
  logic          load, skip, cap_we, finish;
  logic [3:0]    cap_idx;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    load          = 1'b0;
    skip          = 1'b0;
    cap_we        = 1'b0;
    cap_idx       = '0;
    finish        = 1'b0;
    kg_en_o       = 1'b0;
    kg_gen_key_o  = 1'b0;
    kg_next_rnd_o = 1'b0;
    kg_rcon_o     = '0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
`ifdef AES_KEY_REUSE_EN
          skip = valid_q && (key_i == key_q);
`endif
          if (!skip) begin
            load    = 1'b1;
            state_d = EXPAND;
            cnt_d   = 4'd1;
          end
        end
      end
      EXPAND: begin
        kg_en_o       = 1'b1;
        kg_gen_key_o  = 1'b1;
        kg_next_rnd_o = (cnt_q != 4'd1);
        kg_rcon_o     = RCON[cnt_q];
        // aes_key_gen registers its result, so this cycle sees the previous round's key
        cap_we        = (cnt_q != 4'd1);
        cap_idx       = cnt_q - 4'd1;
        if (cnt_q == CNT_LAST) state_d = FINAL;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      FINAL: begin
        cap_we  = 1'b1;
        cap_idx = CNT_LAST;
        finish  = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= finish | skip;
      if (load) begin
        key_q   <= key_i;
        valid_q <= 1'b0;
      end else if (finish) begin
        valid_q <= 1'b1;
      end
    end
  end

  // Store contents are only exposed once valid_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load)   store[0]       <= key_i;
    if (cap_we) store[cap_idx] <= kg_rnd_key_i;
  end

  assign busy_o       = (state_q == EXPAND) || (state_q == FINAL);
  assign done_o       = done_q;
  assign keys_valid_o = valid_q;
  assign kg_key_o     = key_q;
  assign dbg_state_o  = state_q;
  assign rd_key_o     = (valid_q && (rd_idx_i <= IDX_LAST)) ? store[rd_idx_i] : '0;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: behavioural aes_key_gen stand-in, FIPS-197 vectors,
// cycle-level control table, corner sequences and random keys against a word-level key expansion.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         start_i = 1'b0;
  logic [127:0] key_i = '0;
  logic         busy_o, done_o, keys_valid_o;
  logic         kg_en_o, kg_gen_key_o, kg_next_rnd_o;
  logic [7:0]   kg_rcon_o;
  logic [127:0] kg_key_o, kg_rnd_key_i, rd_key_o;
  logic [3:0]   rd_idx_i = '0;
  logic [1:0]   dbg_state;

  aes_key_sched_ctrl #(.NRND(10), .IDXW(4)) dut (
    .clk(clk), .nrst(nrst), .start_i(start_i), .key_i(key_i),
    .busy_o(busy_o), .done_o(done_o), .keys_valid_o(keys_valid_o),
    .kg_en_o(kg_en_o), .kg_gen_key_o(kg_gen_key_o), .kg_next_rnd_o(kg_next_rnd_o),
    .kg_rcon_o(kg_rcon_o), .kg_key_o(kg_key_o), .kg_rnd_key_i(kg_rnd_key_i),
    .rd_idx_i(rd_idx_i), .rd_key_o(rd_key_o), .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- GF(2^8) helpers and S-box ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] key_round(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = subword({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // ---------------- aes_key_gen stand-in (registered round key) ----------------
  logic [127:0] kg_reg;
  always @(posedge clk)
    if (kg_en_o) kg_reg <= key_round(kg_next_rnd_o ? kg_reg : kg_key_o, kg_rcon_o);
  assign kg_rnd_key_i = kg_reg;

  // ---------------- scoreboard ----------------
  int           n_vec = 0;
  int           n_err = 0;
  logic [127:0] exp_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // FIPS-197 word-array expansion; fills exp_q with round keys 0..10
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    exp_q.delete();
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_q.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
  endtask

  task automatic verify_store(input logic [127:0] key, input string tag);
    logic [127:0] exp;
    model_expand(key);
    for (int idx = 0; idx < 16; idx++) begin
      @(negedge clk);
      rd_idx_i = idx[3:0];
      #1;
      exp = (idx < 11) ? exp_q.pop_front() : '0;
      check($sformatf("%s rd[%0d]", tag, idx), rd_key_o, exp);
    end
  endtask

  // ---------------- control-sequence table ----------------
  logic [12:0] ctrl_tbl [1:11];
  logic [7:0]  rcon_lit [10];

  function automatic logic [12:0] ctrl_now();
    return {keys_valid_o, busy_o, kg_en_o, kg_gen_key_o, kg_next_rnd_o, kg_rcon_o};
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- driver: one full expansion ----------------
  task automatic run_expand(input logic [127:0] key, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    start_i = 1'b1;
    key_i   = key;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      if (done_o) lat = n;
      else if (n <= 11) check($sformatf("%s ctrl c%0d", tag, n), ctrl_now(), ctrl_tbl[n]);
      start_i = (n == 5);
      key_i   = rand_key();
    end
    start_i = 1'b0;
    check($sformatf("%s done latency", tag), lat, 12);
    if (lat != 0) begin
      @(negedge clk);
      check($sformatf("%s done single", tag), {done_o, keys_valid_o, busy_o}, 3'b010);
      check($sformatf("%s kg_key hold", tag), kg_key_o, key);
    end
  endtask

  // ---------------- rd table for the FIPS-197 key ----------------
  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] exp;
  } rd_vec_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rd_vec_t      rd_tbl [5];
    logic [127:0] k2, k3, k4;
    int           done_at [$];
    int           d0, d1;

    for (int v = 0; v < 256; v++) begin
      logic [7:0] b, inv;
      b   = v[7:0];
      inv = (b == 8'h00) ? 8'h00 : 8'h01;
      if (b != 8'h00) for (int i = 0; i < 254; i++) inv = gmul(inv, b);
      sbox_t[v] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    rcon_lit = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int k = 1; k <= 10; k++) ctrl_tbl[k] = {1'b0, 1'b1, 1'b1, 1'b1, (k > 1), rcon_lit[k-1]};
    ctrl_tbl[11] = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    rd_tbl[0] = '{idx: 4'd0,  exp: FIPS_KEY};
    rd_tbl[1] = '{idx: 4'd1,  exp: 128'ha0fafe1788542cb123a339392a6c7605};
    rd_tbl[2] = '{idx: 4'd10, exp: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    rd_tbl[3] = '{idx: 4'd11, exp: 128'h0};
    rd_tbl[4] = '{idx: 4'd15, exp: 128'h0};

    // reset
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("reset ctrl", {busy_o, done_o, keys_valid_o, kg_en_o, kg_gen_key_o, kg_next_rnd_o, kg_rcon_o}, '0);
    check("reset kg_key", kg_key_o, '0);
    rd_idx_i = 4'd3;
    #1;
    check("rd before schedule", rd_key_o, '0);

    // FIPS-197 key
    run_expand(FIPS_KEY, "fips");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rd_idx_i = rd_tbl[i].idx;
      #1;
      check($sformatf("fips tbl idx %0d", rd_tbl[i].idx), rd_key_o, rd_tbl[i].exp);
    end
    verify_store(FIPS_KEY, "fips");

    // start_i held high: one expansion at a time, next one starts in the done cycle
    k2 = rand_key();
    k3 = rand_key();
    @(negedge clk);
    start_i = 1'b1;
    key_i   = k2;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done_o) done_at.push_back(n);
      if (n == 11) check("held kg_key stable", kg_key_o, k2);
      if (n == 13) check("held second busy", busy_o, 1'b1);
      if (n == 6)  key_i = k3;
      if (n >= 24) start_i = 1'b0;
    end
    d0 = (done_at.size() > 0) ? done_at[0] : -1;
    d1 = (done_at.size() > 1) ? done_at[1] : -1;
    check("held done count", done_at.size(), 2);
    check("held done cycles", {d0, d1}, {32'd12, 32'd24});
    verify_store(k3, "held");

    // asynchronous reset in the middle of an expansion
    @(negedge clk);
    start_i = 1'b1;
    key_i   = rand_key();
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    check("pre-reset rcon", kg_rcon_o, 8'h10);
    nrst = 1'b0;
    #1;
    check("mid reset ctrl", {busy_o, done_o, keys_valid_o, kg_en_o, kg_gen_key_o, kg_next_rnd_o, kg_rcon_o}, '0);
    check("mid reset kg_key", kg_key_o, '0);
    for (int idx = 0; idx < 16; idx++) begin
      @(negedge clk);
      rd_idx_i = idx[3:0];
      #1;
      check($sformatf("mid reset rd[%0d]", idx), rd_key_o, '0);
    end
    @(negedge clk);
    nrst = 1'b1;
    k4 = rand_key();
    run_expand(k4, "post reset");
    verify_store(k4, "post reset");

    // restart with the same key
`ifdef AES_KEY_REUSE_EN
    @(negedge clk);
    start_i = 1'b1;
    key_i   = k4;
    @(negedge clk);
    start_i = 1'b0;
    check("reuse done", {busy_o, done_o, keys_valid_o, kg_en_o}, 4'b0110);
    @(negedge clk);
    check("reuse single", {busy_o, done_o, keys_valid_o, kg_en_o}, 4'b0010);
    verify_store(k4, "reuse");
`else
    run_expand(k4, "same key");
    verify_store(k4, "same key");
`endif

    // random keys
    for (int t = 0; t < 4; t++) begin
      k2 = rand_key();
      run_expand(k2, $sformatf("rand%0d", t));
      verify_store(k2, $sformatf("rand%0d", t));
      for (int j = 0; j < 4; j++) begin
        int ri;
        ri = $urandom_range(0, 15);
        model_expand(k2);
        @(negedge clk);
        rd_idx_i = ri[3:0];
        #1;
        check($sformatf("rand%0d rd[%0d]", t, ri), rd_key_o, (ri < 11) ? exp_q[ri] : 128'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
